change_dispense_sequencer: RTL and testbench

//  Sequences change return for the vending controller. On start it takes the change owed and

---
 rtl/change_dispense_sequencer.sv | 179 +++++++++++++++++
 tb/tb_change_dispense_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_sequencer.sv
// Greedy change dispenser: issues 20/10/5 coins to three hoppers via req/ack, tracking stock per denomination.
// Optional build macro CHANGE_STOCK_LOW_EN adds the registered stock_low flags.
module change_dispense_sequencer #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_STOCK  = 4,
  parameter int ACK_TIMEOUT = 15
`ifdef CHANGE_STOCK_LOW_EN
  ,
  parameter int LOW_THRESH  = 2
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  output logic [2:0]       coin_req,
  input  logic             coin_ack,
  input  logic             refill_vld,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_qty,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
`ifdef CHANGE_STOCK_LOW_EN
  ,
  output logic [2:0]       stock_low
`endif
);

  typedef enum logic [1:0] {IDLE, PICK, ISSUE, DONE} state_t;

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] V5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] V10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] V20 = AMT_W'(20);
  localparam logic [CNT_W:0] STOCK_MAX = {1'b0, {CNT_W{1'b1}}};

  state_t state, state_next;
  logic [1:0] sel, sel_next;
  logic [AMT_W-1:0] remaining_next;
  logic short_next, fault_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [CNT_W-1:0] stock5, stock10, stock20;
  logic accept;
  logic pick_found;
  logic [1:0] pick_sel;
  logic [AMT_W-1:0] sel_value;

  // Denomination index encoding: 0 = 5, 1 = 10, 2 = 20.
  always_comb begin
    pick_found = 1'b1;
    pick_sel   = 2'd0;
    if (remaining >= V20 && stock20 != '0) begin
      pick_sel = 2'd2;
    end else if (remaining >= V10 && stock10 != '0) begin
      pick_sel = 2'd1;
    end else if (remaining >= V5 && stock5 != '0) begin
      pick_sel = 2'd0;
    end else begin
      pick_found = 1'b0;
    end
  end

  always_comb begin
    case (sel)
      2'd2:    sel_value = V20;
      2'd1:    sel_value = V10;
      default: sel_value = V5;
    endcase
  end

  always_comb begin
    state_next     = state;
    sel_next       = sel;
    remaining_next = remaining;
    short_next     = short;
    fault_next     = fault;
    wait_next      = wait_cnt;
    accept         = 1'b0;
    coin_req       = 3'b000;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_next = change_amt;
          short_next     = 1'b0;
          fault_next     = 1'b0;
          state_next     = (change_amt == '0) ? DONE : PICK;
        end
      end
      PICK: begin
        busy = 1'b1;
        if (pick_found) begin
          sel_next   = pick_sel;
          wait_next  = '0;
          state_next = ISSUE;
        end else begin
          short_next = (remaining != '0);
          state_next = DONE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        coin_req = 3'b001 << sel;
        if (coin_ack) begin
          accept         = 1'b1;
          remaining_next = remaining - sel_value;
          state_next     = PICK;
        end else if (wait_cnt == WAIT_LAST) begin
          fault_next = 1'b1;
          short_next = (remaining != '0);
          state_next = DONE;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Refill and a dispensed coin may hit the same hopper in one cycle; the net change saturates.
  function automatic logic [CNT_W-1:0] next_stock(input logic [CNT_W-1:0] cur,
                                                  input logic add,
                                                  input logic [CNT_W-1:0] qty,
                                                  input logic take);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, qty} : {(CNT_W+1){1'b0}}) - {{CNT_W{1'b0}}, take};
    return (sum > STOCK_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= 2'd0;
      remaining <= '0;
      short     <= 1'b0;
      fault     <= 1'b0;
      wait_cnt  <= '0;
      stock5    <= CNT_W'(INIT_STOCK);
      stock10   <= CNT_W'(INIT_STOCK);
      stock20   <= CNT_W'(INIT_STOCK);
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      remaining <= remaining_next;
      short     <= short_next;
      fault     <= fault_next;
      wait_cnt  <= wait_next;
      stock5    <= next_stock(stock5, refill_vld && refill_sel == 2'd0, refill_qty,
                              accept && sel == 2'd0);
      stock10   <= next_stock(stock10, refill_vld && refill_sel == 2'd1, refill_qty,
                              accept && sel == 2'd1);
      stock20   <= next_stock(stock20, refill_vld && refill_sel == 2'd2, refill_qty,
                              accept && sel == 2'd2);
    end
  end

`ifdef CHANGE_STOCK_LOW_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stock_low <= 3'b000;
    end else begin
      stock_low <= {stock20 <= CNT_W'(LOW_THRESH),
                    stock10 <= CNT_W'(LOW_THRESH),
                    stock5  <= CNT_W'(LOW_THRESH)};
    end
  end
`endif

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Directed bench for change_dispense_sequencer: hand-computed coin sequences, stock, short/fault and reset cases.
module tb_change_dispense_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] change_amt;
  logic [2:0] coin_req;
  logic       coin_ack;
  logic       refill_vld;
  logic [1:0] refill_sel;
  logic [5:0] refill_qty;
  logic       busy;
  logic       done;
  logic       short;
  logic       fault;
  logic [7:0] remaining;
`ifdef CHANGE_STOCK_LOW_EN
  logic [2:0] stock_low;
`endif

  int vectorCount = 0;
  int missCount   = 0;
  logic [2:0] coinLog[$];
  int reqCycles;
  int firstReq;
  bit doneSeen;

  change_dispense_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .change_amt (change_amt),
    .coin_req   (coin_req),
    .coin_ack   (coin_ack),
    .refill_vld (refill_vld),
    .refill_sel (refill_sel),
    .refill_qty (refill_qty),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .fault      (fault),
    .remaining  (remaining)
`ifdef CHANGE_STOCK_LOW_EN
    ,
    .stock_low  (stock_low)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] amt);
    start      = 1'b1;
    change_amt = amt;
    step();
    start      = 1'b0;
  endtask

  task automatic refill(input logic [1:0] which, input logic [5:0] qty);
    refill_vld = 1'b1;
    refill_sel = which;
    refill_qty = qty;
    step();
    refill_vld = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Runs until the done pulse, acking each request one cycle after it appears when ackEn is set.
  task automatic runSequence(input bit ackEn);
    coinLog.delete();
    reqCycles = 0;
    firstReq  = -1;
    doneSeen  = 1'b0;
    for (int c = 0; c < 200 && !doneSeen; c++) begin
      step();
      if (done) doneSeen = 1'b1;
      if (coin_req != 3'b000) begin
        reqCycles++;
        if (firstReq < 0) firstReq = c;
        if (ackEn && !coin_ack) begin
          coinLog.push_back(coin_req);
          coin_ack = 1'b1;
        end
      end else begin
        coin_ack = 1'b0;
      end
    end
    coin_ack = 1'b0;
    checkOutput("done_seen", 32'(doneSeen), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    change_amt = '0;
    coin_ack   = 1'b0;
    refill_vld = 1'b0;
    refill_sel = '0;
    refill_qty = '0;
    step();
    step();
    checkOutput("rst_coin_req", 32'(coin_req), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_short", 32'(short), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_remaining", 32'(remaining), 0);
    checkOutput("rst_stock5", 32'(dut.stock5), 4);
    checkOutput("rst_stock20", 32'(dut.stock20), 4);
`ifdef CHANGE_STOCK_LOW_EN
    checkOutput("rst_stock_low", 32'(stock_low), 0);
`endif
    reset_n = 1'b1;
    step();

    // 35 = 20 + 10 + 5
    $display("[TB] case 1: amount 35");
    applyStimulus(8'd35);
    checkOutput("t1_busy_after_start", 32'(busy), 1);
    checkOutput("t1_req_after_start", 32'(coin_req), 0);
    runSequence(1'b1);
    checkOutput("t1_first_req_latency", 32'(firstReq), 0);
    checkOutput("t1_ncoins", 32'(coinLog.size()), 3);
    if (coinLog.size() == 3) begin
      checkOutput("t1_coin0", 32'(coinLog[0]), 32'b100);
      checkOutput("t1_coin1", 32'(coinLog[1]), 32'b010);
      checkOutput("t1_coin2", 32'(coinLog[2]), 32'b001);
    end
    checkOutput("t1_short", 32'(short), 0);
    checkOutput("t1_fault", 32'(fault), 0);
    checkOutput("t1_busy_at_done", 32'(busy), 0);
    checkOutput("t1_remaining", 32'(remaining), 0);
    checkOutput("t1_stock5", 32'(dut.stock5), 3);
    checkOutput("t1_stock10", 32'(dut.stock10), 3);
    checkOutput("t1_stock20", 32'(dut.stock20), 3);
    step();
    checkOutput("t1_done_one_cycle", 32'(done), 0);

    $display("[TB] case 2: amount 7");
    applyStimulus(8'd7);
    runSequence(1'b1);
    checkOutput("t2_ncoins", 32'(coinLog.size()), 1);
    if (coinLog.size() == 1) checkOutput("t2_coin0", 32'(coinLog[0]), 32'b001);
    checkOutput("t2_remaining", 32'(remaining), 2);
    checkOutput("t2_short", 32'(short), 1);
    step();

    // Drain the 20 and 10 hoppers, then 20 must come out as four 5s.
    $display("[TB] case 3: greedy fallback");
    doReset();
    applyStimulus(8'd80);
    runSequence(1'b1);
    checkOutput("t3a_ncoins", 32'(coinLog.size()), 4);
    checkOutput("t3a_stock20", 32'(dut.stock20), 0);
    step();
    applyStimulus(8'd40);
    runSequence(1'b1);
    checkOutput("t3b_ncoins", 32'(coinLog.size()), 4);
    if (coinLog.size() == 4) checkOutput("t3b_coin3", 32'(coinLog[3]), 32'b010);
    checkOutput("t3b_stock10", 32'(dut.stock10), 0);
    step();
    applyStimulus(8'd20);
    runSequence(1'b1);
    checkOutput("t3c_ncoins", 32'(coinLog.size()), 4);
    if (coinLog.size() == 4) begin
      checkOutput("t3c_coin0", 32'(coinLog[0]), 32'b001);
      checkOutput("t3c_coin3", 32'(coinLog[3]), 32'b001);
    end
    checkOutput("t3c_short", 32'(short), 0);
    checkOutput("t3c_remaining", 32'(remaining), 0);
    checkOutput("t3c_stock5", 32'(dut.stock5), 0);
    step();
    applyStimulus(8'd5);
    runSequence(1'b1);
    checkOutput("t3d_ncoins", 32'(coinLog.size()), 0);
    checkOutput("t3d_short", 32'(short), 1);
    checkOutput("t3d_remaining", 32'(remaining), 5);
    step();

    $display("[TB] case 4: ack timeout");
    refill(2'd1, 6'd2);
    checkOutput("t4_refill10", 32'(dut.stock10), 2);
    applyStimulus(8'd10);
    runSequence(1'b0);
    checkOutput("t4_req_cycles", 32'(reqCycles), 15);
    checkOutput("t4_fault", 32'(fault), 1);
    checkOutput("t4_short", 32'(short), 1);
    checkOutput("t4_req_at_done", 32'(coin_req), 0);
    checkOutput("t4_remaining", 32'(remaining), 10);
    checkOutput("t4_stock10", 32'(dut.stock10), 2);
    step();

    $display("[TB] case 5: refill saturation and coincident refill/dispense");
    refill(2'd2, 6'd4);
    checkOutput("t5_stock20_4", 32'(dut.stock20), 4);
    refill(2'd2, 6'd63);
    checkOutput("t5_stock20_sat", 32'(dut.stock20), 63);
    refill(2'd3, 6'd5);
    checkOutput("t5_sel3_ignored", 32'(dut.stock5), 0);
    applyStimulus(8'd10);
    checkOutput("t5_fault_cleared", 32'(fault), 0);
    checkOutput("t5_short_cleared", 32'(short), 0);
    step();
    checkOutput("t5_req10", 32'(coin_req), 32'b010);
    coin_ack   = 1'b1;
    refill_vld = 1'b1;
    refill_sel = 2'd1;
    refill_qty = 6'd1;
    step();
    coin_ack   = 1'b0;
    refill_vld = 1'b0;
    checkOutput("t5_stock10_net", 32'(dut.stock10), 2);
    checkOutput("t5_remaining", 32'(remaining), 0);
    runSequence(1'b1);
    checkOutput("t5_short", 32'(short), 0);
    step();

    $display("[TB] case 6: zero amount and reset during ISSUE");
    applyStimulus(8'd0);
    checkOutput("t6_done_zero", 32'(done), 1);
    checkOutput("t6_busy_zero", 32'(busy), 0);
    step();
    checkOutput("t6_done_drop", 32'(done), 0);
    checkOutput("t6_busy_after", 32'(busy), 0);
    applyStimulus(8'd20);
    step();
    checkOutput("t6_req20", 32'(coin_req), 32'b100);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_req", 32'(coin_req), 0);
    checkOutput("t6_async_busy", 32'(busy), 0);
    checkOutput("t6_stock5", 32'(dut.stock5), 4);
    checkOutput("t6_stock10", 32'(dut.stock10), 4);
    checkOutput("t6_stock20", 32'(dut.stock20), 4);
    #3;
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
